// File: rtl/pc_unit_if.sv
// Request/response bundle between the fetch controller and the PC unit.
// The master drives redirect requests; the slave (pc_unit) returns the PC and RAS status.
interface pc_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             stall;
  logic             trap;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic             jump;
  logic             call;
  logic [WIDTH-1:0] jump_target;
  logic             ret;
  logic [WIDTH-1:0] pc_out;
  logic             pc_valid;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_underflow;

  modport master (
    output stall, trap, branch_taken, branch_target, jump, call, jump_target, ret,
    input  pc_out, pc_valid, ras_empty, ras_full, ras_underflow
  );

  modport slave (
    input  stall, trap, branch_taken, branch_target, jump, call, jump_target, ret,
    output pc_out, pc_valid, ras_empty, ras_full, ras_underflow
  );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit: sequential increment, stall, prioritised redirects
// (trap > branch > stall > call > jump > ret) and a circular return-address stack.
module pc_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      INC          = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(256),
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input logic      clk,
  input logic      reset,
  pc_unit_if.slave bus
);

  localparam int unsigned PtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             valid_q, valid_d;
  logic             under_q, under_d;
  logic [PtrW-1:0]  top_q, top_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

  assign pc_inc = pc_q + WIDTH'(INC);

  // Next-state selection by fixed priority; exactly one action per cycle.
  always_comb begin
    pc_d    = pc_q;
    valid_d = 1'b1;
    under_d = 1'b0;
    top_d   = top_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    if (!valid_q) begin
      // First edge out of reset: hold the reset vector for one cycle and mark it valid.
      pc_d = RESET_VECTOR;
    end else if (bus.trap) begin
      pc_d  = TRAP_VECTOR;
      cnt_d = '0;
    end else if (bus.branch_taken) begin
      pc_d = bus.branch_target;
    end else if (bus.stall) begin
      pc_d = pc_q;
    end else if (bus.call) begin
      pc_d  = bus.jump_target;
      push  = 1'b1;
      // Pointer wraps naturally; when full the new entry lands on the oldest slot.
      top_d = top_q + PtrW'(1);
      if (cnt_q != CntFull) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end else if (bus.jump) begin
      pc_d = bus.jump_target;
    end else if (bus.ret) begin
      if (cnt_q != '0) begin
        pc_d  = ras_mem[top_q];
        top_d = top_q - PtrW'(1);
        cnt_d = cnt_q - CntW'(1);
      end else begin
        pc_d    = pc_inc;
        under_d = 1'b1;
      end
    end else begin
      pc_d = pc_inc;
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q    <= RESET_VECTOR;
      valid_q <= 1'b0;
      under_q <= 1'b0;
      top_q   <= '0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      under_q <= under_d;
      top_q   <= top_d;
      cnt_q   <= cnt_d;
    end
  end

  // Return-address storage; contents are meaningless beyond the count, so no reset.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      ras_mem[top_d] <= pc_inc;
    end
  end

  assign bus.pc_out        = pc_q;
  assign bus.pc_valid      = valid_q;
  assign bus.ras_underflow = under_q;
  assign bus.ras_empty     = (cnt_q == '0);
  assign bus.ras_full      = (cnt_q == CntFull);

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a queue-based RAS model predicts every cycle's outputs.
module tb_pc_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic        valid;
    logic        empty;
    logic        full;
    logic        under;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic reset8 = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  exp_t        sb [$];
  logic [31:0] m_ras [$];
  logic [31:0] m_pc = '0;
  logic        m_valid = 1'b0;
  logic        m_under = 1'b0;

  pc_unit_if #(.WIDTH(32)) bus ();
  pc_unit_if #(.WIDTH(8))  bus8 ();

  pc_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  pc_unit #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (reset8),
    .bus   (bus8)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour for one clock edge, pushing the predicted outputs.
  task automatic model_step(input logic rst, input logic st, input logic tr, input logic br,
                            input logic [31:0] bt, input logic jp, input logic cl,
                            input logic [31:0] jt, input logic rt);
    exp_t e;
    m_under = 1'b0;
    if (!rst) begin
      m_pc = 32'h0;
      m_valid = 1'b0;
      m_ras.delete();
    end else if (!m_valid) begin
      m_valid = 1'b1;
      m_pc = 32'h0;
    end else if (tr) begin
      m_pc = 32'h100;
      m_ras.delete();
    end else if (br) begin
      m_pc = bt;
    end else if (st) begin
      m_pc = m_pc;
    end else if (cl) begin
      m_ras.push_back(m_pc + 32'd4);
      if (m_ras.size() > 4) void'(m_ras.pop_front());
      m_pc = jt;
    end else if (jp) begin
      m_pc = jt;
    end else if (rt) begin
      if (m_ras.size() > 0) begin
        m_pc = m_ras.pop_back();
      end else begin
        m_pc = m_pc + 32'd4;
        m_under = 1'b1;
      end
    end else begin
      m_pc = m_pc + 32'd4;
    end
    e.pc    = m_pc;
    e.valid = m_valid;
    e.empty = (m_ras.size() == 0);
    e.full  = (m_ras.size() == 4);
    e.under = m_under;
    sb.push_back(e);
  endtask

  // Drive one cycle of stimulus on the falling edge and record the prediction.
  task automatic cyc(input logic rst, input logic st, input logic tr, input logic br,
                     input logic [31:0] bt, input logic jp, input logic cl,
                     input logic [31:0] jt, input logic rt);
    @(negedge clk);
    reset             = rst;
    bus.stall         = st;
    bus.trap          = tr;
    bus.branch_taken  = br;
    bus.branch_target = bt;
    bus.jump          = jp;
    bus.call          = cl;
    bus.jump_target   = jt;
    bus.ret           = rt;
    model_step(rst, st, tr, br, bt, jp, cl, jt, rt);
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic do_call(input logic [31:0] t);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, t, 1'b0);
  endtask

  task automatic do_jump(input logic [31:0] t);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, t, 1'b0);
  endtask

  task automatic do_ret();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  // Direct check of pc_out just after the edge that consumes the last driven cycle.
  task automatic chk_pc(input string tag, input logic [31:0] exp);
    @(posedge clk);
    #2;
    check_eq(tag, bus.pc_out, exp);
  endtask

  // Scoreboard: pop the prediction for each edge and compare every output.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq("sb_pc", bus.pc_out, e.pc);
      check_eq("sb_valid", 32'(bus.pc_valid), 32'(e.valid));
      check_eq("sb_empty", 32'(bus.ras_empty), 32'(e.empty));
      check_eq("sb_full", 32'(bus.ras_full), 32'(e.full));
      check_eq("sb_under", 32'(bus.ras_underflow), 32'(e.under));
    end
  end

  initial begin
    bus.stall = 1'b0; bus.trap = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = '0;
    bus.jump = 1'b0; bus.call = 1'b0; bus.jump_target = '0; bus.ret = 1'b0;
    bus8.stall = 1'b0; bus8.trap = 1'b0; bus8.branch_taken = 1'b0; bus8.branch_target = '0;
    bus8.jump = 1'b0; bus8.call = 1'b0; bus8.jump_target = '0; bus8.ret = 1'b0;

    // Reset, then free run.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 1'b0);
    chk_pc("reset_pc", 32'h0);
    check_eq("reset_valid", 32'(bus.pc_valid), 32'h0);
    idle(); chk_pc("first_after_reset", 32'h0);
    check_eq("valid_after_reset", 32'(bus.pc_valid), 32'h1);
    idle(); chk_pc("run_4", 32'h4);
    idle(); chk_pc("run_8", 32'h8);

    // Stall versus redirects.
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk_pc("stall_hold", 32'h8);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 1'b0);
    chk_pc("stall_beats_jump", 32'h8);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 1'b0);
    chk_pc("branch_beats_stall", 32'h80);

    // Nested call/return.
    do_jump(32'h10); chk_pc("jump_10", 32'h10);
    do_call(32'h100); chk_pc("call_100", 32'h100);
    idle(); chk_pc("run_104", 32'h104);
    do_call(32'h200); chk_pc("call_200", 32'h200);
    do_ret(); chk_pc("ret_108", 32'h108);
    do_ret(); chk_pc("ret_14", 32'h14);
    check_eq("nest_empty", 32'(bus.ras_empty), 32'h1);

    // Overflow: five calls into a four-entry stack.
    do_jump(32'h0);
    do_call(32'h20); do_call(32'h40); do_call(32'h60); do_call(32'h80);
    do_call(32'h300); chk_pc("call_300", 32'h300);
    check_eq("ovf_full", 32'(bus.ras_full), 32'h1);
    do_ret(); chk_pc("ovf_ret_84", 32'h84);
    do_ret(); chk_pc("ovf_ret_64", 32'h64);
    do_ret(); chk_pc("ovf_ret_44", 32'h44);
    do_ret(); chk_pc("ovf_ret_24", 32'h24);
    do_ret(); chk_pc("underflow_pc", 32'h28);
    check_eq("underflow_flag", 32'(bus.ras_underflow), 32'h1);
    idle(); chk_pc("after_underflow", 32'h2C);
    check_eq("underflow_pulse", 32'(bus.ras_underflow), 32'h0);

    // Trap beats branch and call, flushes the stack.
    do_call(32'h500); do_call(32'h600);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'h80, 1'b0, 1'b1, 32'h700, 1'b0);
    chk_pc("trap_pc", 32'h100);
    check_eq("trap_empty", 32'(bus.ras_empty), 32'h1);

    // Wrap at the top of a 32-bit address space.
    do_jump(32'hFFFF_FFFC); chk_pc("jump_top", 32'hFFFF_FFFC);
    idle(); chk_pc("wrap_0", 32'h0);

    // Reset in the same cycle as a call.
    do_call(32'h900); do_call(32'hA00);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 1'b0);
    chk_pc("mid_reset_pc", 32'h0);
    check_eq("mid_reset_empty", 32'(bus.ras_empty), 32'h1);
    idle(); idle(); chk_pc("post_reset_run", 32'h4);

    // Random traffic, including the call+ret collision and occasional reset.
    for (int i = 0; i < 400; i++) begin
      logic r_rst, r_st, r_tr, r_br, r_jp, r_cl, r_rt;
      r_rst = ($urandom_range(0, 59) != 0);
      r_st  = ($urandom_range(0, 5) == 0);
      r_tr  = ($urandom_range(0, 24) == 0);
      r_br  = ($urandom_range(0, 9) == 0);
      r_jp  = ($urandom_range(0, 7) == 0);
      r_cl  = ($urandom_range(0, 3) == 0);
      r_rt  = ($urandom_range(0, 2) == 0);
      cyc(r_rst, r_st, r_tr, r_br, $urandom(), r_jp, r_cl, $urandom(), r_rt);
    end
    idle();
    repeat (3) @(posedge clk);
    #2;
    check_eq("sb_drained", 32'(sb.size()), 32'h0);

    // 8-bit instance: wrap from 0xFC to 0x00.
    @(negedge clk); reset8 = 1'b1;
    @(posedge clk); #2;
    check_eq("w8_first", 32'(bus8.pc_out), 32'h0);
    check_eq("w8_valid", 32'(bus8.pc_valid), 32'h1);
    @(negedge clk); bus8.jump = 1'b1; bus8.jump_target = 8'hFC;
    @(posedge clk); #2;
    check_eq("w8_jump_fc", 32'(bus8.pc_out), 32'hFC);
    @(negedge clk); bus8.jump = 1'b0;
    @(posedge clk); #2;
    check_eq("w8_wrap_00", 32'(bus8.pc_out), 32'h0);
    @(posedge clk); #2;
    check_eq("w8_run_04", 32'(bus8.pc_out), 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit; successor to the single-register PC.
- Adds the following on top of a plain PC register:
  - sequential increment
  - stall/hold
  - branch, jump, call and trap redirects with fixed priority
  - small circular return-address stack (RAS) for call/return
- Sits at the head of the fetch stage; pc_out drives the instruction-memory address.

Parameters:
- WIDTH, 32, address width in bits.
- INC, 4, sequential increment added to pc_out each advancing cycle.
- RESET_VECTOR, 0, pc_out value while reset is asserted and on the first cycle after release.
- TRAP_VECTOR, 256 (0x100), pc_out value loaded on trap.
- RAS_DEPTH, 4, number of return-address entries (power of 2, at least 2).

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- stall  in  1  hold pc_out; overridden by trap and branch_taken.
- trap  in  1  redirect to TRAP_VECTOR and flush the RAS.
- branch_taken  in  1  redirect to branch_target.
- branch_target  in  WIDTH  branch destination.
- jump  in  1  redirect to jump_target; no RAS effect.
- call  in  1  redirect to jump_target and push pc_out+INC.
- jump_target  in  WIDTH  destination for jump/call.
- ret  in  1  pop the RAS and redirect to the popped address.
- pc_out  out  WIDTH  current PC (registered).
- pc_valid  out  1  0 while in reset; 1 from the first clk edge with reset=1.
- ras_empty  out  1  RAS holds 0 entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.
- ras_underflow  out  1  one-cycle pulse: ret accepted while RAS empty.

Behaviour:
- All state updates on rising clk only; every output is registered except ras_empty/ras_full, which are decoded from the registered count.
- Reset (reset==0 at the edge):
  - pc_out=RESET_VECTOR, pc_valid=0, RAS count=0, ras_underflow=0.
  - Reset overrides all other inputs, including mid-redirect.
- Next-PC priority, highest first; one action per cycle, all lower-priority requests in that cycle are ignored:
  1. trap: pc_out<=TRAP_VECTOR; RAS count<=0; ignores stall.
  2. branch_taken: pc_out<=branch_target; RAS unchanged; ignores stall.
  3. stall: pc_out held; jump/call/ret ignored (no push, no pop).
  4. call: pc_out<=jump_target; push (pc_out+INC) mod 2^WIDTH.
  5. jump: pc_out<=jump_target.
  6. ret: if RAS non-empty, pc_out<=top entry and count decrements. If empty, pc_out<=pc_out+INC and ras_underflow=1 for exactly one cycle.
  7. otherwise: pc_out<=(pc_out+INC) mod 2^WIDTH; wraps silently from the top of the address space to 0.
- Simultaneous-request cases resolved by the priority above:
  - call with jump: treated as call.
  - call with ret: call wins and ret is dropped.
- Latency: a redirect requested in cycle N appears on pc_out after edge N+1 (one cycle).
- RAS organisation:
  - Circular buffer: top pointer plus count, range 0..RAS_DEPTH.
  - Push when full overwrites the oldest entry; count stays at RAS_DEPTH and ras_full stays 1. No error flag.
  - Pop after an overflow returns the newest entries in LIFO order. After RAS_DEPTH pops the stack is empty; overwritten entries are lost.
- Targets are used unmodified; no alignment masking.
- ras_underflow is 0 in every cycle other than an accepted underflowing ret.

Test Plan:
- Reset then free-run, defaults: reset=0 for 2 cycles, then 1 -> pc_out=0x0 and pc_valid=0 during reset; afterwards pc_out steps 0x0, 0x4, 0x8, 0xC and pc_valid=1.
- Stall vs redirect: at pc_out=0x8, stall=1 for 3 cycles -> pc_out holds 0x8. stall=1 with jump=1, jump_target=0x40 -> still 0x8. stall=1 with branch_taken=1, branch_target=0x80 -> 0x80 next cycle.
- Call/return nesting: call to 0x100 from pc 0x10, then call to 0x200 from pc 0x104 -> subsequent rets yield 0x108, then 0x14; ras_empty=1 after both.
- RAS overflow: 5 calls with RAS_DEPTH=4, from pcs 0x0, 0x20, 0x40, 0x60, 0x80 -> ras_full=1. Four rets return 0x84, 0x64, 0x44, 0x24. A 5th ret gives pc_out+4 and ras_underflow=1 for one cycle.
- Priority collision: trap=1, branch_taken=1, call=1 in the same cycle with 2 RAS entries -> pc_out=0x100, ras_empty=1, no push.
- Wrap-around and mid-operation reset:
  - With WIDTH=8, load pc_out=0xFC via jump -> next pc_out=0x00.
  - Assert reset=0 in the same cycle as call=1 -> pc_out=RESET_VECTOR and RAS empty.
